mem_axil_master: RTL and testbench

//  MEM-stage load/store unit for the pipelined RV32I core. Takes one load/store request per

---
 rtl/yarc_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 68 ++++++
 rtl/mem_axil_master.sv | 186 ++++++++++++++++++
 tb/tb_mem_axil_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarc_pkg.sv
// Shared constants for the RV32I MEM-stage load/store unit.
// Latency: n/a (constants, types and one helper only).
// Backpressure: n/a.
package yarc_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // State encodings for the bus-transaction FSM
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_WR_B = 3'd2;
  localparam logic [2:0] ST_RD_A = 3'd3;
  localparam logic [2:0] ST_RD_D = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_WR   = ST_WR,
    S_WR_B = ST_WR_B,
    S_RD_A = ST_RD_A,
    S_RD_D = ST_RD_D,
    S_DONE = ST_DONE
  } state_t;

  // Any response other than OKAY is a fault; EXOKAY is not legal on AXI4-Lite.
  function automatic logic resp_err(input logic [1:0] resp);
    case (resp)
      RESP_OKAY:                resp_err = 1'b0;
      RESP_SLVERR, RESP_DECERR: resp_err = 1'b1;
      default:                  resp_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for stores and extraction/extension for loads.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
  import yarc_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Decode size/sign from funct3, build strobes/replicated data or extend the read lane
  always_comb begin
    wstrb      = 4'b0000;
    wdata      = 32'h0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    ld_data    = 32'h0;
    shifted    = ld_raw >> {addr_lo, 3'b000};
    if (we) begin
      case (funct3)
        F3_SB: begin
          wstrb = 4'b0001 << addr_lo;
          wdata = {4{st_data[7:0]}};
        end
        F3_SH: begin
          wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
          wdata      = {2{st_data[15:0]}};
          misaligned = addr_lo[0];
        end
        F3_SW: begin
          wstrb      = 4'b1111;
          wdata      = st_data;
          misaligned = |addr_lo;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
        F3_LBU: ld_data = {24'h0, shifted[7:0]};
        F3_LH: begin
          ld_data    = {{16{shifted[15]}}, shifted[15:0]};
          misaligned = addr_lo[0];
        end
        F3_LHU: begin
          ld_data    = {16'h0, shifted[15:0]};
          misaligned = addr_lo[0];
        end
        F3_LW: begin
          ld_data    = shifted;
          misaligned = |addr_lo;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_axil_master.sv
// MEM-stage load/store unit: one request becomes one AXI4-Lite read or write.
// Latency: 4 cycles minimum (IDLE, RD_A/WR, RD_D/WR_B, DONE); 2 cycles for faults.
// Backpressure: holds mem_stall until the bus completes; AXI valids held until ready.
module mem_axil_master
  import yarc_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  logic        al_we;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic        al_misaligned;
  logic        al_illegal;
  logic [31:0] al_ld_data;

  logic        fault;
  logic        aw_done;
  logic        w_done;
  logic        b_err;
  logic        r_err;

  assign m_awprot = PROT;
  assign m_arprot = PROT;

  // The EX/MEM fields are only sampled in IDLE; later the registered copies drive extraction
  assign al_we      = (state == S_IDLE) ? req_we             : we_q;
  assign al_funct3  = (state == S_IDLE) ? req_funct3         : funct3_q;
  assign al_addr_lo = (state == S_IDLE) ? req_addr[1:0]      : addr_lo_q;

  lsu_align u_align (
    .we         (al_we),
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .st_data    (req_wdata),
    .ld_raw     (m_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal),
    .ld_data    (al_ld_data)
  );

  assign fault = al_misaligned | al_illegal;

  // A channel is finished once its valid is already down or is handshaking this cycle
  assign aw_done = !m_awvalid || m_awready;
  assign w_done  = !m_wvalid  || m_wready;

  assign b_err = resp_err(m_bresp);
  assign r_err = resp_err(m_rresp);

  // Low in DONE so the pipeline registers advance on the completing edge
  assign mem_stall = req_valid && (state != S_DONE);

  // Transaction FSM with registered AXI and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= 32'h0;
      m_wstrb   <= 4'b0000;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            if (fault) begin
              // Misaligned or illegal: report without touching the bus
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              rsp_valid <= 1'b1;
              state     <= S_DONE;
            end else if (req_we) begin
              m_awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              m_wdata   <= al_wdata;
              m_wstrb   <= al_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= S_WR;
            end else begin
              m_araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              m_arvalid <= 1'b1;
              state     <= S_RD_A;
            end
          end
        end
        S_WR: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_bready <= 1'b1;
            state    <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            rsp_err   <= b_err;
            rsp_rdata <= 32'h0;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_RD_A: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= S_RD_D;
          end
        end
        S_RD_D: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            rsp_err   <= r_err;
            rsp_rdata <= r_err ? 32'h0 : al_ld_data;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axil_master.sv
// Scoreboard bench for mem_axil_master with a delay-configurable AXI4-Lite slave.
// Latency: expected cycle counts are carried with each queued response.
// Backpressure: slave ready/valid delays are set per directed vector.
module tb_mem_axil_master;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } rexp_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } wexp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  int tests = 0;
  int fails = 0;

  rexp_t       rsp_q[$];
  logic [31:0] aw_q[$];
  wexp_t       w_q[$];
  logic [31:0] ar_q[$];

  int stall_cnt   = 0;
  int aw_only_cnt = 0;
  int base_cnt;
  bit seen;

  // slave configuration
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit aw_got, w_got, ar_got;

  mem_axil_master #(.ADDR_W(32), .PROT(3'b000)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_stall  (mem_stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .m_awaddr   (m_awaddr),
    .m_awprot   (m_awprot),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready),
    .m_araddr   (m_araddr),
    .m_arprot   (m_arprot),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave: readies rise once the valid has waited its configured delay
  assign m_awready = m_awvalid && (aw_cnt >= aw_dly);
  assign m_wready  = m_wvalid  && (w_cnt  >= w_dly);
  assign m_arready = m_arvalid && (ar_cnt >= ar_dly);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      m_bvalid <= 1'b0; m_rvalid <= 1'b0;
    end else begin
      if (m_awvalid && !m_awready) aw_cnt <= aw_cnt + 1; else aw_cnt <= 0;
      if (m_wvalid && !m_wready)   w_cnt  <= w_cnt + 1;  else w_cnt  <= 0;
      if (m_arvalid && !m_arready) ar_cnt <= ar_cnt + 1; else ar_cnt <= 0;
      if (m_awvalid && m_awready) aw_got <= 1'b1;
      if (m_wvalid && m_wready)   w_got  <= 1'b1;
      if (m_arvalid && m_arready) ar_got <= 1'b1;
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
      end else if (!m_bvalid && (aw_got || (m_awvalid && m_awready))
                             && (w_got  || (m_wvalid && m_wready))) begin
        if (b_cnt >= b_dly) m_bvalid <= 1'b1; else b_cnt <= b_cnt + 1;
      end
      if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
      end else if (!m_rvalid && (ar_got || (m_arvalid && m_arready))) begin
        if (r_cnt >= r_dly) m_rvalid <= 1'b1; else r_cnt <= r_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: bus handshakes, AXI hold rule and responses against the queues
  initial begin
    bit pa, pw, par;
    rexp_t r;
    wexp_t w;
    pa = 0; pw = 0; par = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0; pa = 0; pw = 0; par = 0;
      end else begin
        if (req_valid && mem_stall) stall_cnt++;
        if (pa)  chk("awvalid_hold", {31'b0, m_awvalid}, 1);
        if (pw)  chk("wvalid_hold",  {31'b0, m_wvalid},  1);
        if (par) chk("arvalid_hold", {31'b0, m_arvalid}, 1);
        pa  = m_awvalid && !m_awready;
        pw  = m_wvalid  && !m_wready;
        par = m_arvalid && !m_arready;
        if (m_awvalid && !m_wvalid) aw_only_cnt++;

        if (aw_q.size() == 0) chk("aw_unexpected", {31'b0, m_awvalid}, 0);
        else if (m_awvalid && m_awready) begin
          chk("awaddr", m_awaddr, aw_q.pop_front());
          chk("awprot", {29'b0, m_awprot}, 0);
        end
        if (w_q.size() == 0) chk("w_unexpected", {31'b0, m_wvalid}, 0);
        else if (m_wvalid && m_wready) begin
          w = w_q.pop_front();
          chk("wdata", m_wdata, w.d);
          chk("wstrb", {28'b0, m_wstrb}, {28'b0, w.s});
        end
        if (ar_q.size() == 0) chk("ar_unexpected", {31'b0, m_arvalid}, 0);
        else if (m_arvalid && m_arready) begin
          chk("araddr", m_araddr, ar_q.pop_front());
          chk("arprot", {29'b0, m_arprot}, 0);
        end

        if (rsp_valid) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", {31'b0, rsp_valid}, 0);
          else begin
            r = rsp_q.pop_front();
            chk("rsp_err",   {31'b0, rsp_err}, {31'b0, r.err});
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("latency",   stall_cnt + 1, r.lat);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // issue one request, wait for its completion pulse, release on the DONE edge
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd,
                       input int lat);
    bit got;
    got = 0;
    rsp_q.push_back(rexp_t'{err, rd, lat});
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    chk("rsp_timeout", {31'b0, got}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {25'b0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'b0, mem_stall}, 0);
    @(posedge clk); #1;

    // SW aligned, all readies immediate
    aw_q.push_back(32'h100); w_q.push_back(wexp_t'{32'hDEADBEEF, 4'hF});
    drive(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 4);

    // SB to top byte, awready late by 3 cycles
    aw_dly = 3; base_cnt = aw_only_cnt;
    aw_q.push_back(32'h100); w_q.push_back(wexp_t'{32'hA5A5A5A5, 4'b1000});
    drive(1'b1, 3'b000, 32'h103, 32'h000000A5, 1'b0, 32'h0, 7);
    chk("aw_held_alone", aw_only_cnt - base_cnt, 3);
    aw_dly = 0;

    // SH upper half
    aw_q.push_back(32'h100); w_q.push_back(wexp_t'{32'h12341234, 4'b1100});
    drive(1'b1, 3'b001, 32'h102, 32'hFFFF1234, 1'b0, 32'h0, 4);

    // loads of 0x0080FF00
    m_rdata = 32'h0080FF00;
    ar_q.push_back(32'h100); drive(1'b0, 3'b000, 32'h102, 32'h0, 1'b0, 32'hFFFFFF80, 4);
    ar_q.push_back(32'h100); drive(1'b0, 3'b100, 32'h102, 32'h0, 1'b0, 32'h00000080, 4);
    ar_q.push_back(32'h100); drive(1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 32'h00000080, 4);
    ar_q.push_back(32'h100); drive(1'b0, 3'b101, 32'h100, 32'h0, 1'b0, 32'h0000FF00, 4);
    ar_q.push_back(32'h100); drive(1'b0, 3'b001, 32'h100, 32'h0, 1'b0, 32'hFFFFFF00, 4);
    ar_q.push_back(32'h100); drive(1'b0, 3'b000, 32'h101, 32'h0, 1'b0, 32'hFFFFFFFF, 4);
    ar_q.push_back(32'h100); drive(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0080FF00, 4);

    // faults: no bus traffic, 2-cycle completion
    drive(1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h0, 2);
    drive(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 2);
    drive(1'b0, 3'b110, 32'h100, 32'h0, 1'b1, 32'h0, 2);
    drive(1'b1, 3'b100, 32'h100, 32'h0, 1'b1, 32'h0, 2);
    drive(1'b1, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 2);
    drive(1'b1, 3'b001, 32'h101, 32'h0, 1'b1, 32'h0, 2);

    // LW with SLVERR and rvalid late by 5 cycles
    r_dly = 5; m_rresp = 2'b10; m_rdata = 32'h12345678;
    ar_q.push_back(32'h200);
    drive(1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 32'h0, 9);
    r_dly = 0; m_rresp = 2'b00;

    // SW with DECERR
    m_bresp = 2'b11;
    aw_q.push_back(32'h500); w_q.push_back(wexp_t'{32'h01020304, 4'hF});
    drive(1'b1, 3'b010, 32'h500, 32'h01020304, 1'b1, 32'h0, 4);
    m_bresp = 2'b00;

    // reset while waiting for the write response
    b_dly = 10;
    aw_q.push_back(32'h404); w_q.push_back(wexp_t'{32'hCAFEF00D, 4'hF});
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h404; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (m_bready) seen = 1;
    end
    chk("reach_wr_b", {31'b0, seen}, 1);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("mid_rst_ctrl", {26'b0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 0);
    chk("mid_rst_stall", {31'b0, mem_stall}, 0);
    b_dly = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    aw_q.push_back(32'h300); w_q.push_back(wexp_t'{32'h11223344, 4'hF});
    drive(1'b1, 3'b010, 32'h300, 32'h11223344, 1'b0, 32'h0, 4);
    m_rdata = 32'h11223344;
    ar_q.push_back(32'h300);
    drive(1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 32'h11223344, 4);

    @(negedge clk);
    chk("end_idle_stall", {31'b0, mem_stall}, 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("aw_q_empty",  aw_q.size(),  0);
    chk("w_q_empty",   w_q.size(),   0);
    chk("ar_q_empty",  ar_q.size(),  0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
